multi_channel_pulse_timer: RTL and testbench

Parametrised, multi-channel successor to the single-button, fixed-three-cycle laser timer controller. Each of CHANNELS independent channels converts a rising edge on its trigger input into an output pulse of programmable length, followed by an optional guard interval. Per-channel retrigger mode and a one-cycle completion strobe are supported. The block sits between debounced button or sensor inputs and actuator enables.

---
 rtl/multi_channel_pulse_timer_pkg.sv | 20 ++
 rtl/pulse_timer_ch.sv | 89 ++++++++
 rtl/multi_channel_pulse_timer.sv | 39 +++
 tb/tb_multi_channel_pulse_timer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_channel_pulse_timer_pkg.sv
// Shared definitions for the multi-channel pulse timer.
package multi_channel_pulse_timer_pkg;

  // Bit positions of each state in the one-hot encoding
  localparam int unsigned StIdleIdx  = 0;
  localparam int unsigned StOnIdx    = 1;
  localparam int unsigned StGuardIdx = 2;

  typedef enum logic [2:0] {
    StIdle  = 3'b001,
    StOn    = 3'b010,
    StGuard = 3'b100
  } state_e;

  // Effective reload value for a pulse: a zero duration behaves as one cycle
  function automatic logic [31:0] pulse_load(input logic [31:0] dur);
    return (dur == 32'd0) ? 32'd0 : dur - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_timer_ch.sv
// One timer channel: edge detect, IDLE/ON/GUARD FSM, down-counter, registered x/done.
module pulse_timer_ch
  import multi_channel_pulse_timer_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GUARD_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             b_i,
  input  logic [CNT_W-1:0] dur_i,
  input  logic             retrig_i,
  output logic             x_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int unsigned GuardM1 = (GUARD_CYC > 0) ? GUARD_CYC - 1 : 0;
  localparam logic [CNT_W-1:0] GuardLoad = CNT_W'(GuardM1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             b_q;
  logic             x_q;
  logic             done_q;

  logic             rise;
  logic [CNT_W-1:0] load_val;

  assign rise     = b_i & ~b_q;
  assign load_val = CNT_W'(pulse_load(32'(dur_i)));

  // Channel state machine; x and done are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      b_q     <= 1'b0;
      x_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      b_q    <= b_i;
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (rise) begin
            state_q <= StOn;
            cnt_q   <= load_val;
            x_q     <= 1'b1;
          end
        end
        StOn: begin
          if (rise && retrig_i) begin
            cnt_q <= load_val;
          end else if (cnt_q == '0) begin
            x_q    <= 1'b0;
            done_q <= 1'b1;
            if (GUARD_CYC > 0) begin
              state_q <= StGuard;
              cnt_q   <= GuardLoad;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StGuard: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          // Corrupted one-hot state: fall back to a quiet idle channel
          state_q <= StIdle;
          cnt_q   <= '0;
          x_q     <= 1'b0;
        end
      endcase
    end
  end

  assign x_o    = x_q;
  assign done_o = done_q;
  assign busy_o = (state_q != StIdle);

endmodule

// File: rtl/multi_channel_pulse_timer.sv
// CHANNELS independent edge-triggered pulse timers sharing one duration input.
module multi_channel_pulse_timer
  import multi_channel_pulse_timer_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned GUARD_CYC = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] b_i,
  input  logic [CNT_W-1:0]    dur_i,
  input  logic [CHANNELS-1:0] retrig_i,
  output logic [CHANNELS-1:0] x_o,
  output logic [CHANNELS-1:0] done_o,
  output logic                busy_o
);

  logic [CHANNELS-1:0] ch_busy;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulse_timer_ch #(
      .CNT_W    (CNT_W),
      .GUARD_CYC(GUARD_CYC)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .b_i     (b_i[i]),
      .dur_i   (dur_i),
      .retrig_i(retrig_i[i]),
      .x_o     (x_o[i]),
      .done_o  (done_o[i]),
      .busy_o  (ch_busy[i])
    );
  end

  assign busy_o = |ch_busy;

endmodule

// File: tb/tb_multi_channel_pulse_timer.sv
// Scoreboard bench: stimulus pushes expected pulse widths, a monitor measures each pulse.
module tb_multi_channel_pulse_timer;

  localparam int CH = 4;
  localparam int CW = 8;

  typedef struct {
    int d;
    int c;
    int w;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] b0, b2, retrig;
  logic [CW-1:0] dur;
  logic [CH-1:0] x_g0, done_g0, x_g2, done_g2;
  logic          busy_g0, busy_g2;

  logic [CH-1:0] x_a    [2];
  logic [CH-1:0] done_a [2];
  assign x_a[0]    = x_g0;
  assign x_a[1]    = x_g2;
  assign done_a[0] = done_g0;
  assign done_a[1] = done_g2;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  multi_channel_pulse_timer #(
    .CHANNELS(CH), .CNT_W(CW), .GUARD_CYC(0)
  ) u_dut_g0 (
    .clk(clk), .rst_n(rst_n), .b_i(b0), .dur_i(dur), .retrig_i(retrig),
    .x_o(x_g0), .done_o(done_g0), .busy_o(busy_g0)
  );

  multi_channel_pulse_timer #(
    .CHANNELS(CH), .CNT_W(CW), .GUARD_CYC(2)
  ) u_dut_g2 (
    .clk(clk), .rst_n(rst_n), .b_i(b2), .dur_i(dur), .retrig_i(retrig),
    .x_o(x_g2), .done_o(done_g2), .busy_o(busy_g2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int d, input int c, input int w);
    exp_t e;
    e.d = d; e.c = c; e.w = w;
    sb.push_back(e);
  endtask

  // Monitor: measure every x pulse, require done at its fall, match width against the queue
  int            width  [2][CH];
  logic [CH-1:0] x_prev [2];
  initial begin
    for (int d = 0; d < 2; d++) begin
      x_prev[d] = '0;
      for (int c = 0; c < CH; c++) width[d][c] = 0;
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        if (!rst_n) begin
          if (x_prev[d][c]) check($sformatf("abort_no_done d%0d c%0d", d, c), 32'(done_a[d][c]), 0);
          width[d][c] = 0;
        end else if (x_a[d][c]) begin
          width[d][c]++;
        end else if (x_prev[d][c]) begin
          int found;
          found = -1;
          check($sformatf("done_at_fall d%0d c%0d", d, c), 32'(done_a[d][c]), 1);
          foreach (sb[i]) if (found < 0 && sb[i].d == d && sb[i].c == c) found = i;
          if (found < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse d%0d c%0d: got width %0d, expected no pulse",
                     d, c, width[d][c]);
          end else begin
            check($sformatf("pulse_width d%0d c%0d", d, c), 32'(width[d][c]), 32'(sb[found].w));
            sb.delete(found);
          end
          width[d][c] = 0;
        end else if (done_a[d][c]) begin
          check($sformatf("spurious_done d%0d c%0d", d, c), 32'(done_a[d][c]), 0);
        end
        x_prev[d][c] = x_a[d][c];
      end
    end
  end

  initial begin
    logic [6:0] pat;
    rst_n  = 1'b0;
    b0     = '0;
    b2     = '0;
    retrig = '0;
    dur    = 8'd3;
    tick(2);
    check("rst_x_g0", 32'(x_g0), 0);
    check("rst_done_g0", 32'(done_g0), 0);
    check("rst_busy_g0", 32'(busy_g0), 0);
    check("rst_x_g2", 32'(x_g2), 0);
    check("rst_done_g2", 32'(done_g2), 0);
    check("rst_busy_g2", 32'(busy_g2), 0);
    rst_n = 1'b1;
    tick(1);

    // Async reset during the 2nd ON cycle of ch0
    b2[0] = 1'b1;
    tick(1);
    check("abort_x_on", 32'(x_g2[0]), 1);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_x_async", 32'(x_g2), 0);
    check("abort_done_async", 32'(done_g2), 0);
    check("abort_busy_async", 32'(busy_g2), 0);
    b2 = '0;
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Basic 3-cycle pulse, no guard, level held high
    dur = 8'd3;
    push(0, 0, 3);
    b0[0] = 1'b1;
    tick(10);
    b0[0] = 1'b0;
    tick(4);

    // Zero duration gives a single-cycle pulse
    dur = 8'd0;
    push(1, 1, 1);
    b2[1] = 1'b1;
    tick(1);
    b2[1] = 1'b0;
    tick(5);

    // Edge during guard is lost; a later edge is accepted
    dur = 8'd5;
    push(1, 1, 5);
    b2[1] = 1'b1;
    tick(1);
    b2[1] = 1'b0;
    tick(5);
    check("guard_busy", 32'(busy_g2), 1);
    check("guard_x_low", 32'(x_g2[1]), 0);
    b2[1] = 1'b1;
    tick(1);
    b2[1] = 1'b0;
    tick(2);
    check("guard_over_busy", 32'(busy_g2), 0);
    push(1, 1, 5);
    b2[1] = 1'b1;
    tick(1);
    b2[1] = 1'b0;
    tick(10);

    // Retrigger on 3rd and 6th ON cycles, then the same edges without retrigger
    dur = 8'd4;
    pat = 7'b0100101;
    retrig[2] = 1'b1;
    push(1, 2, 9);
    for (int j = 0; j < 7; j++) begin
      b2[2] = pat[j];
      tick(1);
    end
    tick(14);
    retrig[2] = 1'b0;
    push(1, 2, 4);
    for (int j = 0; j < 7; j++) begin
      b2[2] = pat[j];
      tick(1);
    end
    tick(10);

    // All channels at once; dur changes after the trigger is latched
    dur = 8'd6;
    for (int c = 0; c < CH; c++) begin
      push(0, c, 6);
      push(1, c, 6);
    end
    b0 = '1;
    b2 = '1;
    tick(1);
    check("conc_x_on", 32'(x_g2), 32'hF);
    dur = 8'd2;
    b0  = '0;
    b2  = '0;
    tick(6);
    check("conc_done_g2", 32'(done_g2), 32'hF);
    check("conc_done_g0", 32'(done_g0), 32'hF);
    check("conc_x_off", 32'(x_g2), 0);
    check("conc_busy_guard", 32'(busy_g2), 1);
    check("conc_busy_g0_idle", 32'(busy_g0), 0);
    tick(1);
    check("conc_busy_guard2", 32'(busy_g2), 1);
    check("conc_done_once", 32'(done_g2), 0);
    tick(1);
    check("conc_busy_idle", 32'(busy_g2), 0);
    tick(5);

    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
